// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: copies xfer_len words from src to dst via read/write bus pairs.
// Optional DMA_FIXED_DST_EN adds dst_fixed, which holds the write address constant (IO FIFO).
module dma_xfer_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
`ifdef DMA_FIXED_DST_EN
    input  logic                  dst_fixed,
`endif
    input  logic                  abort,
    input  logic                  irq_clr,
    output logic                  busy,
    output logic                  done_irq,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdReq  = 3'd1;
    localparam logic [2:0] StRdWait = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StFinish = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, words_q, words_d, words_inc;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  done_q, done_d, aborted_q, aborted_d;
    logic                  abort_pend_q, abort_pend_d;
`ifdef DMA_FIXED_DST_EN
    logic                  fixed_q, fixed_d;
`endif

    assign words_inc = words_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        words_d      = words_q;
        buf_d        = buf_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
`ifdef DMA_FIXED_DST_EN
        fixed_d      = fixed_q;
`endif
        // Clear first so a FINISH set in the same cycle takes priority.
        if (irq_clr) begin
            done_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    len_d        = xfer_len;
                    words_d      = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
`ifdef DMA_FIXED_DST_EN
                    fixed_d      = dst_fixed;
`endif
                    state_d      = (xfer_len == '0) ? StFinish : StRdReq;
                end
            end
            StRdReq: begin
                if (m_gnt) begin
                    abort_pend_d = abort;
                    state_d      = StRdWait;
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StFinish;
                end
            end
            StRdWait: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (m_rvalid) begin
                    if (abort_pend_q || abort) begin
                        aborted_d = 1'b1;
                        state_d   = StFinish;
                    end else begin
                        buf_d   = m_rdata;
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                if (m_gnt) begin
                    words_d = words_inc;
                    src_d   = src_q + Stride;
`ifdef DMA_FIXED_DST_EN
                    dst_d   = fixed_q ? dst_q : dst_q + Stride;
`else
                    dst_d   = dst_q + Stride;
`endif
                    if (abort || words_inc == len_q) begin
                        aborted_d = abort;
                        state_d   = StFinish;
                    end else begin
                        state_d = StRdReq;
                    end
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_q      <= '0;
            buf_q        <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
`ifdef DMA_FIXED_DST_EN
            fixed_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            words_q      <= words_d;
            buf_q        <= buf_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
`ifdef DMA_FIXED_DST_EN
            fixed_q      <= fixed_d;
`endif
        end
    end

    // Bus outputs decode straight from state so reset drops m_req asynchronously.
    assign busy       = (state_q != StIdle);
    assign done_irq   = done_q;
    assign aborted    = aborted_q;
    assign words_done = words_q;
    assign m_req      = (state_q == StRdReq) || (state_q == StWrReq);
    assign m_we       = (state_q == StWrReq);
    assign m_addr     = (state_q == StRdReq) ? src_q :
                        (state_q == StWrReq) ? dst_q : '0;
    assign m_wdata    = (state_q == StWrReq) ? buf_q : '0;

endmodule
